// File: rtl/sevseg_pair_to_binary.sv
// Two-digit seven-segment (active-low {a..g}) reader: debounces the pair, then decodes it to 0..15.
// Optional saturating illegal-pattern counter on err_cnt when SEVSEG_ERRCNT_EN is defined.
module sevseg_pair_to_binary #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_s,
  input  logic [6:0] seg_r,
  output logic [3:0] value,
  output logic       valid,
  output logic       err
`ifdef SEVSEG_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StHold, StSettle} state_e;

  state_e          state_q, state_d;
  logic [13:0]     snap_q, snap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      value_q, value_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [13:0] sample;
  logic [3:0]  ones;
  logic        ones_ok, tens, tens_ok, legal;
  logic [4:0]  sum;

  assign sample = {seg_r, seg_s};

  // Decode works on the snapshot, which equals the input on the decode edge.
  always_comb begin
    ones    = 4'd0;
    ones_ok = 1'b1;
    case (snap_q[6:0])
      7'b0000001: ones = 4'd0;
      7'b1001111: ones = 4'd1;
      7'b0010010: ones = 4'd2;
      7'b0000110: ones = 4'd3;
      7'b1001100: ones = 4'd4;
      7'b0100100: ones = 4'd5;
      7'b0100000: ones = 4'd6;
      7'b0001111: ones = 4'd7;
      7'b0000000: ones = 4'd8;
      7'b0001100: ones = 4'd9;
      default:    ones_ok = 1'b0;
    endcase
    tens    = 1'b0;
    tens_ok = 1'b1;
    case (snap_q[13:7])
      7'b0000001: tens = 1'b0;
      7'b1001111: tens = 1'b1;
      default:    tens_ok = 1'b0;
    endcase
    sum   = (tens ? 5'd10 : 5'd0) + {1'b0, ones};
    legal = ones_ok && tens_ok && (sum <= 5'd15);
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StHold: begin
        if (sample != snap_q) begin
          snap_d  = sample;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (sample != snap_q) begin
          snap_d = sample;
          cnt_d  = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHold;
          if (legal) begin
            value_d = sum[3:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHold;
      snap_q  <= 14'h3FFF;
      cnt_q   <= '0;
      value_q <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;

`ifdef SEVSEG_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
